// File: rtl/dmem_ctrl.sv
// Data-memory stage for the single-cycle core: byte/half/word stores through
// lane enables, sign/zero-extended combinational loads, fault detection and
// a post-reset clear sequencer that zeroes one word per cycle.
//
// Handshake: the core may only rely on an access when ready_o=1. While
// ready_o=0 (clear in progress) req_i is ignored: nothing is stored,
// r_data_o=0 and fault_o=0, so the core must stall.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 16384,
  parameter bit INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] w_data_i,
  output logic [31:0] r_data_o,
  output logic        ready_o,
  output logic        fault_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // busy_o/ready_o expose the FSM state directly.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam state_t RESET_STATE = INIT_CLEAR ? ST_CLEAR : ST_IDLE;

  state_t          state;
  state_t          state_nx;
  logic [AW-1:0]   clr_idx;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   widx;
  logic [1:0]      off;
  logic            idle;
  logic            wr_en;
  logic            rd_en;
  logic [3:0]      wr_be;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic            unused_addr;

  assign widx        = addr_i[AW+1:2];
  assign off         = addr_i[1:0];
  assign idle        = (state == ST_IDLE);
  // Upper address bits are intentionally dropped: the array wraps.
  assign unused_addr = ^addr_i[31:AW+2];

  // State register: reset restarts the clear from word 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_nx;
  end

  // Clear index advances once per cycle while clearing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
  end

  // Next state and status outputs; the last word written ends the clear.
  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    busy_o   = 1'b0;
    case (state)
      ST_CLEAR: begin
        busy_o = 1'b1;
        if (&clr_idx) state_nx = ST_IDLE;
      end
      ST_IDLE: ready_o = 1'b1;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Fault: illegal size codes, unsigned stores, misaligned half/word.
  always_comb begin
    fault_o = 1'b0;
    if (req_i && idle) begin
      case (funct3_i)
        3'b000:  fault_o = 1'b0;
        3'b001:  fault_o = off[0];
        3'b010:  fault_o = |off;
        3'b100:  fault_o = we_i;
        3'b101:  fault_o = we_i | off[0];
        default: fault_o = 1'b1;
      endcase
    end
  end

  // Store lane enables and lane-replicated store data.
  always_comb begin
    wr_be   = 4'b0000;
    wr_word = w_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << off;
        wr_word = {4{w_data_i[7:0]}};
      end
      2'b01: begin
        wr_be   = off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{w_data_i[15:0]}};
      end
      2'b10: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = req_i & we_i & idle & ~fault_o;
  assign rd_en = req_i & ~we_i & idle & ~fault_o;

  // Array write port: clear has priority, otherwise masked store.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[widx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign rd_word  = mem[widx];
  assign rd_shift = rd_word >> {off, 3'b000};

  // Load extraction and extension; zero when no valid load is in flight.
  always_comb begin
    r_data_o = '0;
    if (rd_en) begin
      case (funct3_i)
        3'b000:  r_data_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
        3'b001:  r_data_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
        3'b010:  r_data_o = rd_word;
        3'b100:  r_data_o = {24'h0, rd_shift[7:0]};
        3'b101:  r_data_o = {16'h0, rd_shift[15:0]};
        default: r_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: clear timing, directed vector table, randomized
// traffic against a byte-array reference model, and reset during clear.
module tb_dmem_ctrl;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  funct3_i = 3'b010;
  logic [31:0] addr_i = '0;
  logic [31:0] w_data_i = '0;
  logic [31:0] r_data_o;
  logic        ready_o;
  logic        fault_o;
  logic        busy_o;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .funct3_i (funct3_i),
    .addr_i   (addr_i),
    .w_data_i (w_data_i),
    .r_data_o (r_data_o),
    .ready_o  (ready_o),
    .fault_o  (fault_o),
    .busy_o   (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  model_b [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic model_fault(input logic req, input logic we,
                                       input logic [2:0] f3, input logic [31:0] a);
    if (!req) return 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (we && f3[2]) return 1'b1;
    return (a % op_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic req, input logic we,
                                             input logic [2:0] f3, input logic [31:0] a);
    int          sz;
    int          base;
    logic [31:0] v;
    if (!req || we || model_fault(req, we, f3, a)) return 32'h0;
    sz   = op_size(f3);
    base = int'(a % (DEPTH * 4));
    v    = 0;
    for (int i = 0; i < sz; i++) v = v + (32'(model_b[base + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic model_store(input logic req, input logic we,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int base;
    if (!req || !we || model_fault(req, we, f3, a)) return;
    base = int'(a % (DEPTH * 4));
    for (int i = 0; i < op_size(f3); i++) model_b[base + i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH * 4; i++) model_b[i] = 8'h00;
  endtask

  // ---------------- driver ----------------
  // Drive after the falling edge; outputs are then sampled 2ns later.
  task automatic drive(input logic req, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i = req; we_i = we; funct3_i = f3; addr_i = a; w_data_i = d;
    #2;
  endtask

  // Counts cycles with ready_o low while an LW 0x0 is held; DUT must
  // keep read data and fault at zero throughout.
  task automatic count_clear(output int n);
    n = 0;
    while (n < 200) begin
      if (ready_o) break;
      chk("clear_rdata", r_data_o, 32'h0);
      chk("clear_fault", 32'(fault_o), 32'h0);
      chk("clear_busy", 32'(busy_o), 32'h1);
      n++;
      @(negedge clk); #2;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int w = 0; w < DEPTH; w++) begin
      drive(1'b1, 1'b0, 3'b010, 32'(w * 4), 32'h0);
      chk(name, r_data_o, 32'h0);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_r;
    logic        exp_f;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic req, input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] er, input logic ef);
    vec_t v;
    v.req = req; v.we = we; v.f3 = f3; v.addr = a; v.wdata = d;
    v.exp_r = er; v.exp_f = ef;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    int n;
    logic [2:0]  rf3;
    logic [31:0] ra;
    logic [31:0] rd;
    logic        rreq;
    logic        rwe;

    // Directed vectors: stores/loads, lane merging, faults, wrap.
    vecs.push_back(mk(1, 1, 3'b010, 32'h8,  32'h8180_7F01, 32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b000, 32'h8,  32'h0,         32'h0000_0001, 0));
    vecs.push_back(mk(1, 0, 3'b000, 32'hA,  32'h0,         32'hFFFF_FF80, 0));
    vecs.push_back(mk(1, 0, 3'b100, 32'hB,  32'h0,         32'h0000_0081, 0));
    vecs.push_back(mk(1, 0, 3'b001, 32'hA,  32'h0,         32'hFFFF_8180, 0));
    vecs.push_back(mk(1, 0, 3'b101, 32'h8,  32'h0,         32'h0000_7F01, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h4,  32'hAABB_CCDD, 32'h0,         0));
    vecs.push_back(mk(1, 1, 3'b000, 32'h5,  32'h0000_0011, 32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h4,  32'h0,         32'hAABB_11DD, 0));
    vecs.push_back(mk(1, 1, 3'b001, 32'h6,  32'h0000_2233, 32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h4,  32'h0,         32'h2233_11DD, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h2,  32'hDEAD_BEEF, 32'h0,         1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0,  32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b001, 32'h3,  32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 0, 3'b011, 32'h0,  32'h0,         32'h0,         1));
    vecs.push_back(mk(1, 1, 3'b100, 32'h8,  32'h0000_00FF, 32'h0,         1));
    vecs.push_back(mk(1, 0, 3'b010, 32'h8,  32'h0,         32'h8180_7F01, 0));
    vecs.push_back(mk(1, 1, 3'b010, 32'h40, 32'h1234_5678, 32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h0,  32'h0,         32'h1234_5678, 0));
    vecs.push_back(mk(0, 0, 3'b010, 32'h8,  32'h0,         32'h0,         0));
    vecs.push_back(mk(1, 0, 3'b010, 32'h3C, 32'h0,         32'h0,         0));

    model_clear();

    // Reset state.
    #12;
    chk("reset_busy", 32'(busy_o), 32'h1);
    chk("reset_ready", 32'(ready_o), 32'h0);

    // Release reset and time the initial clear while holding LW 0x0.
    @(negedge clk);
    rst = 1'b1; req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0;
    #2;
    count_clear(n);
    chk("clear_cycles", 32'(n), 32'(DEPTH));
    chk("ready_after_clear", 32'(ready_o), 32'h1);
    chk("busy_after_clear", 32'(busy_o), 32'h0);
    check_all_zero("lw_after_clear");

    // Directed vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_rdata", i), r_data_o, vecs[i].exp_r);
      chk($sformatf("vec%0d_fault", i), 32'(fault_o), 32'(vecs[i].exp_f));
      model_store(vecs[i].req, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
    end

    // Randomized traffic against the byte-array model.
    for (int k = 0; k < 400; k++) begin
      rreq = ($urandom_range(0, 9) != 0);
      rwe  = $urandom_range(0, 1) == 1;
      rf3  = 3'($urandom_range(0, 7));
      ra   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
      rd   = $urandom;
      drive(rreq, rwe, rf3, ra, rd);
      exp_q.push_back(model_load(rreq, rwe, rf3, ra));
      chk("rand_rdata", r_data_o, exp_q.pop_front());
      chk("rand_fault", 32'(fault_o), 32'(model_fault(rreq, rwe, rf3, ra)));
      model_store(rreq, rwe, rf3, ra, rd);
    end

    // Make sure stored data exists, then reset and re-reset mid-clear.
    drive(1'b1, 1'b1, 3'b010, 32'hC, 32'hCAFE_F00D);
    drive(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
    chk("pre_reset_word", r_data_o, 32'hCAFE_F00D);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'h1);
    chk("rst_ready", 32'(ready_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    #2;
    chk("mid_clear_busy", 32'(busy_o), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0;
    #2;
    count_clear(n);
    chk("restart_clear_cycles", 32'(n), 32'(DEPTH));
    model_clear();
    check_all_zero("lw_after_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
